// File: rtl/spi_servo_cmd_rx_if.sv
// SPI pin bundle and write-port bundle for the servo command receiver.
// slave: the receiver (samples SPI pins, drives the write port).
// master: the SPI source / pulse-register side.
interface spi_servo_cmd_rx_if;
  logic        i_spi_clock;
  logic        i_mosi;
  logic        i_select;
  logic        o_wr_valid;
  logic [7:0]  o_wr_index;
  logic [15:0] o_wr_pulse;
  logic        o_clamped;
  logic        o_frame_err;
  logic        o_busy;

  modport slave (
    input  i_spi_clock, i_mosi, i_select,
    output o_wr_valid, o_wr_index, o_wr_pulse, o_clamped, o_frame_err, o_busy
  );

  modport master (
    output i_spi_clock, i_mosi, i_select,
    input  o_wr_valid, o_wr_index, o_wr_pulse, o_clamped, o_frame_err, o_busy
  );
endinterface

// File: rtl/spi_servo_cmd_rx.sv
// Servo command receiver: oversampled SPI (CPOL=1, CPHA=0, LSB first) into
// 3-byte frames {index, pulse[15:8], pulse[7:0]}, index range check, pulse
// clamp, single-cycle write strobe. Fully synchronous to i_clock.
// Optional: define SERVO_CMD_CHECKSUM_EN for a 4th XOR checksum byte.
module spi_servo_cmd_rx #(
  parameter int NUM_CHANNELS = 12,
  parameter int MIN_PULSE    = 500,
  parameter int MAX_PULSE    = 2500,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  spi_servo_cmd_rx_if.slave    bus
);

  localparam logic [7:0]  NUM_CH = 8'(NUM_CHANNELS);
  localparam logic [15:0] MIN_P  = 16'(MIN_PULSE);
  localparam logic [15:0] MAX_P  = 16'(MAX_PULSE);

  typedef enum logic [2:0] {
    S_IDLE, S_IDX, S_HI, S_LO,
`ifdef SERVO_CMD_CHECKSUM_EN
    S_CHK,
`endif
    S_COMMIT
  } state_t;

  // ---------------- input synchronizers ----------------
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q, settle_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, ss_s, mosi_s, settled;

  assign sck_s   = sck_sync_q[SYNC_STAGES-1];
  assign ss_s    = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign settled = settle_q[SYNC_STAGES-1];

  // Sync chains preset to idle levels. ss_prev only tracks SS once the chain
  // holds real pin samples, so SS already low at reset release never looks
  // like a fresh frame start: SS must be seen high first.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sck_sync_q  <= '1;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      settle_q    <= '0;
      sck_prev_q  <= 1'b1;
      ss_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  bus.i_spi_clock};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0],   bus.i_select};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.i_mosi};
      settle_q    <= {settle_q[SYNC_STAGES-2:0],    1'b1};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= settled ? ss_s : 1'b0;
    end
  end

  // ---------------- frame assembly ----------------
  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d, idx_q, idx_d, hi_q, hi_d;
`ifdef SERVO_CMD_CHECKSUM_EN
  logic [7:0]  lo_q, lo_d;
`endif
  logic        got_q, got_d;
  logic        wr_valid_q, wr_valid_d, clamped_q, clamped_d, frame_err_q, frame_err_d;
  logic [7:0]  wr_index_q, wr_index_d;
  logic [15:0] wr_pulse_q, wr_pulse_d;

  logic        sck_fall, ss_fall, ss_rise, byte_done, do_commit, chk_ok;
  logic [7:0]  byte_w, lo_w;
  logic [15:0] pulse_w;

  assign sck_fall  = sck_prev_q & ~sck_s & ~ss_s & (state_q != S_IDLE);
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s & settled;
  assign byte_done = sck_fall && (bit_cnt_q == 3'd7);
  assign byte_w    = {mosi_s, shift_q[6:0]};

  // Next state, bit capture, commit checks and abort handling
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
`ifdef SERVO_CMD_CHECKSUM_EN
    lo_d        = lo_q;
`endif
    got_d       = got_q;
    wr_valid_d  = 1'b0;
    clamped_d   = 1'b0;
    frame_err_d = 1'b0;
    wr_index_d  = wr_index_q;
    wr_pulse_d  = wr_pulse_q;
    do_commit   = 1'b0;
    chk_ok      = 1'b1;
    lo_w        = byte_w;

    if (sck_fall) begin
      shift_d[bit_cnt_q] = mosi_s;
      bit_cnt_d          = bit_cnt_q + 3'd1;
      got_d              = 1'b1;
    end

    case (state_q)
      S_IDLE: if (ss_fall) state_d = S_IDX;
      S_IDX: if (byte_done) begin
        idx_d   = byte_w;
        state_d = S_HI;
      end
      S_HI: if (byte_done) begin
        hi_d    = byte_w;
        state_d = S_LO;
      end
      S_LO: if (byte_done) begin
`ifdef SERVO_CMD_CHECKSUM_EN
        lo_d    = byte_w;
        state_d = S_CHK;
`else
        do_commit = 1'b1;
`endif
      end
`ifdef SERVO_CMD_CHECKSUM_EN
      S_CHK: if (byte_done) begin
        do_commit = 1'b1;
        lo_w      = lo_q;
        chk_ok    = (byte_w == (idx_q ^ hi_q ^ lo_q));
      end
`endif
      S_COMMIT: state_d = S_IDX;
      default:  state_d = S_IDLE;
    endcase

    pulse_w = {hi_q, lo_w};

    if (do_commit) begin
      state_d = S_COMMIT;
      got_d   = 1'b0;
      if (!chk_ok || idx_q >= NUM_CH) begin
        frame_err_d = 1'b1;
      end else begin
        wr_valid_d = 1'b1;
        wr_index_d = idx_q;
        if (pulse_w < MIN_P) begin
          wr_pulse_d = MIN_P;
          clamped_d  = 1'b1;
        end else if (pulse_w > MAX_P) begin
          wr_pulse_d = MAX_P;
          clamped_d  = 1'b1;
        end else begin
          wr_pulse_d = pulse_w;
        end
      end
    end

    // SS release drops any partial frame; a COMMIT in flight has already
    // produced its strobe, so it is not an error.
    if (ss_rise && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      shift_d   = 8'd0;
      got_d     = 1'b0;
      if (got_q && state_q != S_COMMIT) frame_err_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      idx_q       <= 8'd0;
      hi_q        <= 8'd0;
`ifdef SERVO_CMD_CHECKSUM_EN
      lo_q        <= 8'd0;
`endif
      got_q       <= 1'b0;
      wr_valid_q  <= 1'b0;
      clamped_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wr_index_q  <= 8'd0;
      wr_pulse_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
`ifdef SERVO_CMD_CHECKSUM_EN
      lo_q        <= lo_d;
`endif
      got_q       <= got_d;
      wr_valid_q  <= wr_valid_d;
      clamped_q   <= clamped_d;
      frame_err_q <= frame_err_d;
      wr_index_q  <= wr_index_d;
      wr_pulse_q  <= wr_pulse_d;
    end
  end

  assign bus.o_wr_valid  = wr_valid_q;
  assign bus.o_wr_index  = wr_index_q;
  assign bus.o_wr_pulse  = wr_pulse_q;
  assign bus.o_clamped   = clamped_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_busy      = got_q;

endmodule

// File: tb/tb_spi_servo_cmd_rx.sv
// Randomized self-checking bench for spi_servo_cmd_rx with a frame-level
// reference model (range check + clamp arithmetic, optional XOR checksum).
module tb_spi_servo_cmd_rx;
  localparam int NCH  = 12;
  localparam int MINP = 500;
  localparam int MAXP = 2500;
  localparam int SYNC = 2;
  localparam int HALF = 4;   // SCK = clock/8

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_servo_cmd_rx_if bus();

  spi_servo_cmd_rx #(.NUM_CHANNELS(NCH), .MIN_PULSE(MINP), .MAX_PULSE(MAXP),
                     .SYNC_STAGES(SYNC)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .bus(bus));

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] pulse;
    logic        clamped;
  } wr_t;

  wr_t wr_q[$];
  int  err_cnt   = 0;
  int  cyc       = 0;
  int  valid_cyc = 0;
  int  fall_cyc  = 0;
  int  n_checks  = 0;
  int  n_fail    = 0;
  logic [7:0]  last_idx   = 8'd0;
  logic [15:0] last_pulse = 16'd0;

  always @(posedge clk) cyc++;

  // Observe write and error strobes away from the active edge
  always @(negedge clk) begin
    if (bus.o_wr_valid === 1'b1) begin
      wr_q.push_back('{bus.o_wr_index, bus.o_wr_pulse, bus.o_clamped});
      valid_cyc = cyc;
    end
    if (bus.o_frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: what one frame should produce
  function automatic void model(input int idx, input int p, output bit ok,
                                output int ep, output bit ec);
    ok = (idx < NCH);
    ec = (p < MINP) || (p > MAXP);
    ep = (p < MINP) ? MINP : (p > MAXP) ? MAXP : p;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_mosi = b[i];
      tick(HALF);
      bus.i_spi_clock = 1'b0;
      fall_cyc = cyc;
      tick(HALF);
      bus.i_spi_clock = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] idx, input logic [7:0] hi, input logic [7:0] lo);
    send_bits(idx, 8);
    send_bits(hi, 8);
    send_bits(lo, 8);
`ifdef SERVO_CMD_CHECKSUM_EN
    send_bits(idx ^ hi ^ lo, 8);
`endif
  endtask

  task automatic ss_low();
    bus.i_select = 1'b0;
    tick(HALF);
  endtask

  task automatic ss_high();
    bus.i_select = 1'b1;
    tick(8);
  endtask

  task automatic run_frame(input logic [7:0] idx, input logic [15:0] p);
    ss_low();
    send_frame(idx, p[15:8], p[7:0]);
    ss_high();
  endtask

  task automatic test_reset();
    logic [27:0] obs;
    tick(3);
    obs = {bus.o_wr_valid, bus.o_wr_index, bus.o_wr_pulse, bus.o_clamped, bus.o_frame_err, bus.o_busy};
    n_checks++;
    if (obs !== 28'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic test_basic();
    int e0, lat;
    wr_q.delete(); e0 = err_cnt;
    run_frame(8'h03, 16'h05DC);
    n_checks++;
    if (wr_q.size() !== 1) begin
      n_fail++; $display("FAIL basic_count: got %0d want 1", wr_q.size());
    end else begin
      n_checks++;
      if (wr_q[0].idx !== 8'd3 || wr_q[0].pulse !== 16'd1500 || wr_q[0].clamped !== 1'b0) begin
        n_fail++; $display("FAIL basic_data: got idx=%0d pulse=%0d clamp=%0b want 3/1500/0",
                           wr_q[0].idx, wr_q[0].pulse, wr_q[0].clamped);
      end
      lat = valid_cyc - fall_cyc;
      n_checks++;
      if (lat < SYNC + 1 || lat > SYNC + 2) begin
        n_fail++; $display("FAIL basic_latency: got %0d want %0d..%0d", lat, SYNC + 1, SYNC + 2);
      end
      last_idx = 8'd3; last_pulse = 16'd1500;
    end
    n_checks++;
    if (err_cnt - e0 !== 0) begin
      n_fail++; $display("FAIL basic_err: got %0d want 0", err_cnt - e0);
    end
    n_checks++;
    if (bus.o_wr_index !== 8'd3 || bus.o_wr_pulse !== 16'd1500) begin
      n_fail++; $display("FAIL basic_hold: got %0d/%0d want 3/1500", bus.o_wr_index, bus.o_wr_pulse);
    end
  endtask

  // Directed table plus randomized frames against the model
  task automatic test_frames(input int n_rand);
    int idx, p, ep, e0, sel;
    bit ok, ec;
    for (int k = 0; k < 3 + n_rand; k++) begin
      case (k)
        0: begin idx = 0;  p = 100;  end
        1: begin idx = 11; p = 5000; end
        2: begin idx = 12; p = 1500; end
        default: begin
          idx = $urandom_range(0, 15);
          sel = $urandom_range(0, 3);
          p = (sel == 0) ? $urandom_range(0, 65535) :
              (sel == 1) ? $urandom_range(MINP - 3, MINP + 3) :
              (sel == 2) ? $urandom_range(MAXP - 3, MAXP + 3) : $urandom_range(MINP, MAXP);
        end
      endcase
      model(idx, p, ok, ep, ec);
      wr_q.delete(); e0 = err_cnt;
      run_frame(8'(idx), 16'(p));
      n_checks++;
      if (wr_q.size() !== (ok ? 1 : 0) || err_cnt - e0 !== (ok ? 0 : 1)) begin
        n_fail++; $display("FAIL frame%0d_strobes: got wr=%0d err=%0d want wr=%0d err=%0d (idx=%0d)",
                           k, wr_q.size(), err_cnt - e0, ok ? 1 : 0, ok ? 0 : 1, idx);
      end else if (ok) begin
        n_checks++;
        if (wr_q[0].idx !== 8'(idx) || wr_q[0].pulse !== 16'(ep) || wr_q[0].clamped !== ec) begin
          n_fail++; $display("FAIL frame%0d_data: got %0d/%0d/%0b want %0d/%0d/%0b", k,
                             wr_q[0].idx, wr_q[0].pulse, wr_q[0].clamped, idx, ep, ec);
        end
        last_idx = 8'(idx); last_pulse = 16'(ep);
      end else begin
        n_checks++;
        if (bus.o_wr_index !== last_idx || bus.o_wr_pulse !== last_pulse) begin
          n_fail++; $display("FAIL frame%0d_hold: got %0d/%0d want %0d/%0d", k,
                             bus.o_wr_index, bus.o_wr_pulse, last_idx, last_pulse);
        end
      end
    end
  endtask

  task automatic test_abort();
    int e0;
    wr_q.delete(); e0 = err_cnt;
    ss_low();
    send_bits(8'h5A, 8);
    send_bits(8'hFF, 4);
    tick(2);
    n_checks++;
    if (bus.o_busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_busy: got %b want 1", bus.o_busy);
    end
    ss_high();
    n_checks++;
    if (err_cnt - e0 !== 1 || wr_q.size() !== 0 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_err: got err=%0d wr=%0d busy=%b want 1/0/0",
                         err_cnt - e0, wr_q.size(), bus.o_busy);
    end
    run_frame(8'h01, 16'h07D0);
    n_checks++;
    if (wr_q.size() !== 1 || err_cnt - e0 !== 1) begin
      n_fail++; $display("FAIL abort_next_count: got wr=%0d err=%0d want 1/1", wr_q.size(), err_cnt - e0);
    end else begin
      n_checks++;
      if (wr_q[0].idx !== 8'd1 || wr_q[0].pulse !== 16'd2000 || wr_q[0].clamped !== 1'b0) begin
        n_fail++; $display("FAIL abort_next_data: got %0d/%0d want 1/2000", wr_q[0].idx, wr_q[0].pulse);
      end
      last_idx = 8'd1; last_pulse = 16'd2000;
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    wr_q.delete(); e0 = err_cnt;
    ss_low();
    send_frame(8'h02, 8'h03, 8'hE8);
    send_frame(8'h04, 8'h07, 8'hD0);
    ss_high();
    n_checks++;
    if (wr_q.size() !== 2 || err_cnt - e0 !== 0) begin
      n_fail++; $display("FAIL b2b_count: got wr=%0d err=%0d want 2/0", wr_q.size(), err_cnt - e0);
    end else begin
      n_checks++;
      if (wr_q[0].idx !== 8'd2 || wr_q[0].pulse !== 16'd1000 ||
          wr_q[1].idx !== 8'd4 || wr_q[1].pulse !== 16'd2000) begin
        n_fail++; $display("FAIL b2b_data: got %0d/%0d %0d/%0d want 2/1000 4/2000",
                           wr_q[0].idx, wr_q[0].pulse, wr_q[1].idx, wr_q[1].pulse);
      end
      last_idx = 8'd4; last_pulse = 16'd2000;
    end
  endtask

  task automatic test_reset_mid();
    logic [27:0] obs;
    int e0;
    ss_low();
    send_frame(8'h05, 8'h04, 8'hB0);
    send_bits(8'h06, 8);
    send_bits(8'h07, 2);
    #1 rst_n = 1'b0;
    #1;
    obs = {bus.o_wr_valid, bus.o_wr_index, bus.o_wr_pulse, bus.o_clamped, bus.o_frame_err, bus.o_busy};
    n_checks++;
    if (obs !== 28'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h want 0", obs);
    end
    tick(2);
    rst_n = 1'b1;
    wr_q.delete(); e0 = err_cnt;
    send_bits(8'h07, 6);
    send_bits(8'hD0, 8);
    send_frame(8'h06, 8'h07, 8'h08);
    ss_high();
    n_checks++;
    if (wr_q.size() !== 0 || err_cnt - e0 !== 0) begin
      n_fail++; $display("FAIL midreset_quiet: got wr=%0d err=%0d want 0/0", wr_q.size(), err_cnt - e0);
    end
    run_frame(8'h06, 16'd1800);
    n_checks++;
    if (wr_q.size() !== 1 || err_cnt - e0 !== 0) begin
      n_fail++; $display("FAIL midreset_fresh_count: got wr=%0d err=%0d want 1/0", wr_q.size(), err_cnt - e0);
    end else begin
      n_checks++;
      if (wr_q[0].idx !== 8'd6 || wr_q[0].pulse !== 16'd1800) begin
        n_fail++; $display("FAIL midreset_fresh_data: got %0d/%0d want 6/1800", wr_q[0].idx, wr_q[0].pulse);
      end
      last_idx = 8'd6; last_pulse = 16'd1800;
    end
  endtask

`ifdef SERVO_CMD_CHECKSUM_EN
  task automatic test_checksum();
    int e0;
    wr_q.delete(); e0 = err_cnt;
    ss_low();
    send_bits(8'h03, 8); send_bits(8'h05, 8); send_bits(8'hDC, 8);
    send_bits(8'h00, 8);
    ss_high();
    n_checks++;
    if (wr_q.size() !== 0 || err_cnt - e0 !== 1) begin
      n_fail++; $display("FAIL chk_bad: got wr=%0d err=%0d want 0/1", wr_q.size(), err_cnt - e0);
    end
    n_checks++;
    if (bus.o_wr_index !== last_idx || bus.o_wr_pulse !== last_pulse) begin
      n_fail++; $display("FAIL chk_hold: got %0d/%0d want %0d/%0d",
                         bus.o_wr_index, bus.o_wr_pulse, last_idx, last_pulse);
    end
  endtask
`endif

  initial begin
    bus.i_spi_clock = 1'b1;
    bus.i_mosi      = 1'b0;
    bus.i_select    = 1'b1;
    test_reset();
    test_basic();
    test_frames(12);
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef SERVO_CMD_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
